// File: rtl/axil_regfile_pkg.sv
// Shared types and helpers for the AXI4-Lite register file slave.
package axil_regfile_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    // Number of byte-offset address bits below the register index.
    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axil_regfile_slave_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the register file (slave).
interface axil_regfile_slave_if
    import axil_regfile_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   AWADDR;
    logic [2:0]          AWPROT;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WVALID;
    logic                WREADY;
    resp_t               BRESP;
    logic                BVALID;
    logic                BREADY;
    logic [ADDR_W-1:0]   ARADDR;
    logic [2:0]          ARPROT;
    logic                ARVALID;
    logic                ARREADY;
    logic [DATA_W-1:0]   RDATA;
    resp_t               RRESP;
    logic                RVALID;
    logic                RREADY;

    modport slave (
        input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  ARADDR, ARPROT, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport master (
        output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output ARADDR, ARPROT, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

endinterface

// File: rtl/axil_regfile_wr_ctrl.sv
// Write channel control: independent AW/W holding, commit generation and B response.
module axil_regfile_wr_ctrl
    import axil_regfile_pkg::*;
#(
    parameter int                  DATA_W   = 32,
    parameter int                  IDX_W    = 6,
    parameter int                  NUM_REGS = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [IDX_W-1:0]    aw_idx,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output resp_t               bresp,
    output logic                bvalid,
    input  logic                bready,
    output logic                wr_en,
    output logic [IDX_W-1:0]    wr_idx,
    output logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W/8-1:0] wr_strb
);
    localparam int STRB_W = DATA_W / 8;

    logic              aw_held_r;
    logic              w_held_r;
    logic [IDX_W-1:0]  aw_idx_r;
    logic [DATA_W-1:0] wdata_r;
    logic [STRB_W-1:0] wstrb_r;
    logic              bvalid_r;
    resp_t             bresp_r;

    logic aw_hs_s;
    logic w_hs_s;
    logic commit_s;
    logic idx_ok_s;

    assign awready  = en && !aw_held_r && !bvalid_r;
    assign wready   = en && !w_held_r && !bvalid_r;
    assign aw_hs_s  = awvalid && awready;
    assign w_hs_s   = wvalid && wready;

    // A commit needs both halves, either already held or arriving this cycle.
    assign commit_s = (aw_held_r || aw_hs_s) && (w_held_r || w_hs_s);
    assign wr_idx   = aw_held_r ? aw_idx_r : aw_idx;
    assign wr_data  = w_held_r ? wdata_r : wdata;
    assign wr_strb  = w_held_r ? wstrb_r : wstrb;

    // Index is writable only if it maps onto an existing, non read-only register.
    always_comb begin
        idx_ok_s = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            idx_ok_s = idx_ok_s | ((wr_idx == IDX_W'(i)) && !RO_MASK[i]);
        end
    end

    assign wr_en = commit_s && idx_ok_s;

    // AW and W holding registers; both are released together at commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            aw_idx_r  <= '0;
            wdata_r   <= '0;
            wstrb_r   <= '0;
        end else if (commit_s) begin
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
        end else begin
            if (aw_hs_s) begin
                aw_held_r <= 1'b1;
                aw_idx_r  <= aw_idx;
            end
            if (w_hs_s) begin
                w_held_r <= 1'b1;
                wdata_r  <= wdata;
                wstrb_r  <= wstrb;
            end
        end
    end

    // B channel: response raised on commit, held until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bvalid_r <= 1'b0;
            bresp_r  <= RESP_OKAY;
        end else if (commit_s) begin
            bvalid_r <= 1'b1;
            bresp_r  <= idx_ok_s ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_r && bready) begin
            bvalid_r <= 1'b0;
        end
    end

    assign bvalid = bvalid_r;
    assign bresp  = bresp_r;

endmodule

// File: rtl/axil_regfile_slave.sv
// Parametrised AXI4-Lite register file: byte-strobed RW registers, hardware-sourced RO slots.
module axil_regfile_slave
    import axil_regfile_pkg::*;
#(
    parameter int                    C_DATA_WIDTH = 32,
    parameter int                    C_ADDR_WIDTH = 8,
    parameter int                    C_NUM_REGS   = 16,
    parameter logic [C_NUM_REGS-1:0] C_RO_MASK    = '0
) (
    input  logic                               ACLK,
    input  logic                               ARESETN,
    axil_regfile_slave_if.slave                s_axi,
    input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0] hw_status_i,
    output logic [C_NUM_REGS*C_DATA_WIDTH-1:0] reg_q_o,
    output logic [C_NUM_REGS-1:0]              wr_pulse_o
);
    localparam int LSB    = addr_lsb(C_DATA_WIDTH);
    localparam int IDX_W  = C_ADDR_WIDTH - LSB;
    localparam int STRB_W = C_DATA_WIDTH / 8;

    logic                    run_r;
    logic [C_DATA_WIDTH-1:0] regs_r [C_NUM_REGS];
    logic [C_NUM_REGS-1:0]   wr_pulse_r;
    logic [C_NUM_REGS-1:0]   wr_pulse_nxt_s;

    logic                    wr_en_s;
    logic [IDX_W-1:0]        wr_idx_s;
    logic [C_DATA_WIDTH-1:0] wr_data_s;
    logic [STRB_W-1:0]       wr_strb_s;

    logic [IDX_W-1:0]        rd_idx_s;
    logic                    rd_hit_s;
    logic [C_DATA_WIDTH-1:0] rd_word_s;
    logic                    ar_hs_s;
    logic                    rvalid_r;
    logic [C_DATA_WIDTH-1:0] rdata_r;
    resp_t                   rresp_r;

    logic unused_s;
    assign unused_s = &{1'b0, s_axi.AWPROT, s_axi.ARPROT,
                        s_axi.AWADDR[LSB-1:0], s_axi.ARADDR[LSB-1:0]};

    // Ready outputs stay low until the first clock after reset release.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    axil_regfile_wr_ctrl #(
        .DATA_W   (C_DATA_WIDTH),
        .IDX_W    (IDX_W),
        .NUM_REGS (C_NUM_REGS),
        .RO_MASK  (C_RO_MASK)
    ) u_wr_ctrl (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .en      (run_r),
        .aw_idx  (s_axi.AWADDR[C_ADDR_WIDTH-1:LSB]),
        .awvalid (s_axi.AWVALID),
        .awready (s_axi.AWREADY),
        .wdata   (s_axi.WDATA),
        .wstrb   (s_axi.WSTRB),
        .wvalid  (s_axi.WVALID),
        .wready  (s_axi.WREADY),
        .bresp   (s_axi.BRESP),
        .bvalid  (s_axi.BVALID),
        .bready  (s_axi.BREADY),
        .wr_en   (wr_en_s),
        .wr_idx  (wr_idx_s),
        .wr_data (wr_data_s),
        .wr_strb (wr_strb_s)
    );

    // One-hot pulse for a successful commit that touched at least one byte.
    always_comb begin
        wr_pulse_nxt_s = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            wr_pulse_nxt_s[i] = wr_en_s && (|wr_strb_s) && (wr_idx_s == IDX_W'(i));
        end
    end

    // Register array with byte-lane updates; RO slots are never written and stay 0.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
            wr_pulse_r <= '0;
        end else begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wr_en_s && !C_RO_MASK[i] && (wr_idx_s == IDX_W'(i)) && wr_strb_s[b]) begin
                        regs_r[i][8*b +: 8] <= wr_data_s[8*b +: 8];
                    end
                end
            end
            wr_pulse_r <= wr_pulse_nxt_s;
        end
    end

    // Flatten register contents for the subsystem control logic.
    always_comb begin
        reg_q_o = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            reg_q_o[i*C_DATA_WIDTH +: C_DATA_WIDTH] = regs_r[i];
        end
    end

    assign wr_pulse_o = wr_pulse_r;

    assign rd_idx_s       = s_axi.ARADDR[C_ADDR_WIDTH-1:LSB];
    assign s_axi.ARREADY  = run_r && !rvalid_r;
    assign ar_hs_s        = s_axi.ARVALID && s_axi.ARREADY;

    // Read mux sees the pre-edge array, so a same-cycle write is not visible.
    always_comb begin
        rd_hit_s  = 1'b0;
        rd_word_s = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            rd_hit_s  = rd_hit_s | (rd_idx_s == IDX_W'(i));
            rd_word_s = rd_word_s |
                        ((rd_idx_s == IDX_W'(i)) ?
                         (C_RO_MASK[i] ? hw_status_i[i*C_DATA_WIDTH +: C_DATA_WIDTH] : regs_r[i]) :
                         '0);
        end
    end

    // R channel: data captured at AR handshake and held stable until accepted.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rvalid_r <= 1'b0;
            rdata_r  <= '0;
            rresp_r  <= RESP_OKAY;
        end else if (ar_hs_s) begin
            rvalid_r <= 1'b1;
            rdata_r  <= rd_hit_s ? rd_word_s : '0;
            rresp_r  <= rd_hit_s ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_r && s_axi.RREADY) begin
            rvalid_r <= 1'b0;
        end
    end

    assign s_axi.RVALID = rvalid_r;
    assign s_axi.RDATA  = rdata_r;
    assign s_axi.RRESP  = rresp_r;

endmodule

// File: tb/tb_axil_regfile_slave.sv
// Directed self-checking bench for axil_regfile_slave (16 x 32-bit, reg 15 read-only).
module tb_axil_regfile_slave;
    import axil_regfile_pkg::*;

    localparam logic [15:0] RO_MASK = 16'h8000;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic [511:0] hw_status;
    logic [511:0] reg_q;
    logic [15:0]  wr_pulse;

    int checks = 0;
    int errors = 0;
    int pulse_cnt [16];
    int exp_pulse [16];

    axil_regfile_slave_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    axil_regfile_slave #(
        .C_DATA_WIDTH (32),
        .C_ADDR_WIDTH (8),
        .C_NUM_REGS   (16),
        .C_RO_MASK    (RO_MASK)
    ) dut (
        .ACLK        (aclk),
        .ARESETN     (aresetn),
        .s_axi       (bus),
        .hw_status_i (hw_status),
        .reg_q_o     (reg_q),
        .wr_pulse_o  (wr_pulse)
    );

    always #5 aclk = ~aclk;

    always @(negedge aclk) begin
        for (int i = 0; i < 16; i++) begin
            if (wr_pulse[i]) pulse_cnt[i] = pulse_cnt[i] + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit seen    = 1'b0;
        int n = 0;
        bus.AWADDR = addr; bus.WDATA = data; bus.WSTRB = strb;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.BREADY = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            @(negedge aclk);
            if (bus.AWVALID && bus.AWREADY) aw_done = 1'b1;
            if (bus.WVALID && bus.WREADY) w_done = 1'b1;
            @(posedge aclk); #1;
            if (aw_done) bus.AWVALID = 1'b0;
            if (w_done) bus.WVALID = 1'b0;
            n++;
        end
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        resp = 2'b11;
        n = 0;
        while (!seen && n < 20) begin
            @(negedge aclk);
            if (bus.BVALID) begin
                seen = 1'b1;
                resp = bus.BRESP;
            end
            n++;
        end
        check("wr_bvalid_seen", 64'(seen), 64'd1);
        @(posedge aclk); #1;
        bus.BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit ar_done = 1'b0;
        bit seen    = 1'b0;
        int n = 0;
        bus.ARADDR = addr; bus.ARVALID = 1'b1; bus.RREADY = 1'b1;
        while (!ar_done && n < 20) begin
            @(negedge aclk);
            if (bus.ARREADY) ar_done = 1'b1;
            @(posedge aclk); #1;
            n++;
        end
        bus.ARVALID = 1'b0;
        data = 32'hxxxx_xxxx; resp = 2'b11;
        n = 0;
        while (!seen && n < 20) begin
            @(negedge aclk);
            if (bus.RVALID) begin
                seen = 1'b1;
                data = bus.RDATA;
                resp = bus.RRESP;
            end
            n++;
        end
        check("rd_rvalid_seen", 64'(seen), 64'd1);
        @(posedge aclk); #1;
        bus.RREADY = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  bresp;
        logic [7:0]  raddr;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [31:0] rd;
        logic [1:0]  br;
        logic [1:0]  rr;

        vecs[0] = '{8'h00, 32'h0000_0001, 4'hF, 2'b00, 8'h00, 32'h0000_0001, 2'b00};
        vecs[1] = '{8'h04, 32'h0000_0002, 4'hF, 2'b00, 8'h04, 32'h0000_0002, 2'b00};
        vecs[2] = '{8'h08, 32'h0000_0003, 4'hF, 2'b00, 8'h08, 32'h0000_0003, 2'b00};
        vecs[3] = '{8'h0C, 32'h0000_0004, 4'hF, 2'b00, 8'h0C, 32'h0000_0004, 2'b00};
        vecs[4] = '{8'h00, 32'hAABB_CCDD, 4'hF, 2'b00, 8'h00, 32'hAABB_CCDD, 2'b00};
        vecs[5] = '{8'h00, 32'h1122_3344, 4'h5, 2'b00, 8'h00, 32'hAA22_CC44, 2'b00};
        vecs[6] = '{8'h40, 32'h0000_1234, 4'hF, 2'b10, 8'h40, 32'h0000_0000, 2'b10};
        vecs[7] = '{8'h3C, 32'h0000_5555, 4'hF, 2'b10, 8'h3C, 32'h0000_DEAD, 2'b00};
        vecs[8] = '{8'h05, 32'h0000_0000, 4'h0, 2'b00, 8'h04, 32'h0000_0002, 2'b00};
        vecs[9] = '{8'h13, 32'hCAFE_F00D, 4'hF, 2'b00, 8'h10, 32'hCAFE_F00D, 2'b00};

        for (int i = 0; i < 16; i++) hw_status[i*32 +: 32] = 32'h5100_0000 | 32'(i);
        hw_status[15*32 +: 32] = 32'h0000_DEAD;

        bus.AWADDR = 8'h00; bus.AWPROT = 3'b000; bus.AWVALID = 1'b0;
        bus.WDATA = 32'h0; bus.WSTRB = 4'h0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
        bus.ARADDR = 8'h00; bus.ARPROT = 3'b000; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_ready", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b000);
        check("rst_valid", {bus.BVALID, bus.RVALID, bus.BRESP, bus.RRESP}, 6'b0);
        check("rst_rdata", bus.RDATA, 32'h0);
        check("rst_pulse", wr_pulse, 16'h0);
        check("rst_regq_lo", reg_q[63:0], 64'h0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        check("post_rst_ready", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
        @(posedge aclk); #1;

        // Table-driven write/read-back
        for (int v = 0; v < 10; v++) begin
            axi_write(vecs[v].waddr, vecs[v].wdata, vecs[v].wstrb, br);
            check($sformatf("vec%0d_bresp", v), br, vecs[v].bresp);
            if (vecs[v].bresp == RESP_OKAY && vecs[v].wstrb != 4'h0)
                exp_pulse[vecs[v].waddr[7:2]] = exp_pulse[vecs[v].waddr[7:2]] + 1;
            axi_read(vecs[v].raddr, rd, rr);
            check($sformatf("vec%0d_rdata", v), rd, vecs[v].rdata);
            check($sformatf("vec%0d_rresp", v), rr, vecs[v].rresp);
        end
        for (int i = 0; i < 16; i++) check($sformatf("pulse_cnt%0d", i), pulse_cnt[i], exp_pulse[i]);
        check("regq_slot0", reg_q[31:0], 32'hAA22_CC44);
        check("regq_slot15_ro", reg_q[15*32 +: 32], 32'h0);

        // W arrives three cycles ahead of AW
        bus.WDATA = 32'h0000_005A; bus.WSTRB = 4'hF; bus.WVALID = 1'b1; bus.BREADY = 1'b0;
        @(negedge aclk);
        check("t4_wready", bus.WREADY, 1'b1);
        @(posedge aclk); #1;
        bus.WVALID = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            check("t4_wait", {bus.WREADY, bus.AWREADY, bus.BVALID}, 3'b010);
            @(posedge aclk); #1;
        end
        bus.AWADDR = 8'h08; bus.AWVALID = 1'b1;
        @(negedge aclk);
        check("t4_awready", bus.AWREADY, 1'b1);
        @(posedge aclk); #1;
        bus.AWVALID = 1'b0;
        @(negedge aclk);
        check("t4_bvalid_next", {bus.BVALID, bus.BRESP}, 3'b100);
        @(posedge aclk); #1;
        bus.BREADY = 1'b1;
        @(posedge aclk); #1;
        bus.BREADY = 1'b0;
        axi_read(8'h08, rd, rr);
        check("t4_rdata", rd, 32'h0000_005A);

        // B/R back-pressure for five cycles
        bus.AWADDR = 8'h18; bus.WDATA = 32'h0000_0066; bus.WSTRB = 4'hF;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.ARADDR = 8'h00; bus.ARVALID = 1'b1;
        bus.BREADY = 1'b0; bus.RREADY = 1'b0;
        @(negedge aclk);
        check("bp_accept", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
        @(posedge aclk); #1;
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            check("bp_hold", {bus.BVALID, bus.RVALID, bus.AWREADY, bus.WREADY, bus.ARREADY,
                              bus.BRESP, bus.RRESP}, 9'b1_1000_0000);
            check("bp_rdata", bus.RDATA, 32'hAA22_CC44);
            @(posedge aclk); #1;
        end
        bus.BREADY = 1'b1; bus.RREADY = 1'b1;
        @(negedge aclk);
        check("bp_release_pending", {bus.BVALID, bus.RVALID}, 2'b11);
        @(posedge aclk); #1;
        bus.BREADY = 1'b0; bus.RREADY = 1'b0;
        @(negedge aclk);
        check("bp_after_hs", {bus.BVALID, bus.RVALID, bus.AWREADY, bus.WREADY, bus.ARREADY}, 5'b00111);
        @(posedge aclk); #1;
        axi_write(8'h1C, 32'h0000_0077, 4'hF, br);
        check("bp_next_bresp", br, RESP_OKAY);
        axi_read(8'h18, rd, rr);
        check("bp_reg6", rd, 32'h0000_0066);

        // Read and write of the same register in the same cycle: old value returned
        bus.AWADDR = 8'h08; bus.WDATA = 32'h0000_0099; bus.WSTRB = 4'hF;
        bus.ARADDR = 8'h08; bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.ARVALID = 1'b1;
        bus.BREADY = 1'b1; bus.RREADY = 1'b1;
        @(negedge aclk);
        check("same_accept", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
        @(posedge aclk); #1;
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
        @(negedge aclk);
        check("same_valids", {bus.BVALID, bus.RVALID}, 2'b11);
        check("same_old_value", bus.RDATA, 32'h0000_005A);
        @(posedge aclk); #1;
        bus.BREADY = 1'b0; bus.RREADY = 1'b0;

        // Read issued the cycle after commit sees the new value
        bus.AWADDR = 8'h08; bus.WDATA = 32'h0000_00A5; bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
        bus.BREADY = 1'b1;
        @(negedge aclk);
        check("rac_accept", {bus.AWREADY, bus.WREADY}, 2'b11);
        @(posedge aclk); #1;
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        bus.ARADDR = 8'h08; bus.ARVALID = 1'b1; bus.RREADY = 1'b1;
        @(negedge aclk);
        check("rac_ar_b", {bus.ARREADY, bus.BVALID}, 2'b11);
        @(posedge aclk); #1;
        bus.ARVALID = 1'b0; bus.BREADY = 1'b0;
        @(negedge aclk);
        check("rac_rvalid", bus.RVALID, 1'b1);
        check("rac_new_value", bus.RDATA, 32'h0000_00A5);
        @(posedge aclk); #1;
        bus.RREADY = 1'b0;

        // Reset with W held: held data must be discarded
        bus.WDATA = 32'h0000_0033; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        @(negedge aclk);
        check("mr_wready", bus.WREADY, 1'b1);
        @(posedge aclk); #1;
        bus.WVALID = 1'b0;
        aresetn = 1'b0;
        @(negedge aclk);
        check("mr_ready_low", {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID}, 4'b0000);
        check("mr_regq_clear", reg_q[255:0], 256'h0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        bus.AWADDR = 8'h0C; bus.AWVALID = 1'b1;
        @(negedge aclk);
        check("mr_awready", bus.AWREADY, 1'b1);
        @(posedge aclk); #1;
        bus.AWVALID = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            check("mr_no_stale_commit", {bus.BVALID, bus.WREADY, bus.AWREADY}, 3'b010);
            @(posedge aclk); #1;
        end
        bus.WDATA = 32'h0000_0044; bus.WVALID = 1'b1; bus.BREADY = 1'b1;
        @(negedge aclk);
        @(posedge aclk); #1;
        bus.WVALID = 1'b0;
        @(negedge aclk);
        check("mr_commit", {bus.BVALID, bus.BRESP}, 3'b100);
        @(posedge aclk); #1;
        bus.BREADY = 1'b0;
        axi_read(8'h0C, rd, rr);
        check("mr_reg3", rd, 32'h0000_0044);
        axi_read(8'h00, rd, rr);
        check("mr_reg0_cleared", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
